sweep_pattern_checker: RTL and testbench
========================================

// Module: sweep_pattern_checker
// PURPOSE
//  Receive-side checker for the 8-bit home-interleaved one-hot sweep pattern (home,T1,home,T2,...).
//  Samples the word bus, synchronises to the sweep, reports the current target index and flags deviations.
//  Sits at the far end of a sweep pattern generator link; used for bring-up and for link self-test.
// PARAMETERS
//  DIR        0  sweep direction: 0 = home bit0, targets bit1..bit7 ascending; 1 = home bit7, targets bit6..bit0 descending
//  LOCK_WORDS 4  consecutive correct words (1..15) needed before locked asserts
// PORTS
//  clk          in   1  rising-edge clock (single clock domain)
//  rstn         in   1  asynchronous active-low reset
//  pat          in   8  received pattern word
//  pat_valid    in   1  pat is sampled only when high
//  locked       out  1  checker synchronised to the sweep
//  pos          out  3  bit index of the last accepted target word
//  err          out  1  one-cycle pulse: mismatch while locked
//  period_done  out  1  one-cycle pulse: last target of a sweep accepted (bit7 for DIR=0, bit0 for DIR=1)
//  err_count    out  8  saturating error count (only with SWEEP_CHK_ERRCNT_EN)
// BEHAVIOUR
//  - Reset (async, rstn=0): state=HUNT, locked=0, pos=HOME index, err=0, period_done=0, good_cnt=0, err_count=0.
//  - All outputs registered; response visible on the clock edge after the sampled word (latency 1).
//  - pat_valid=0: state, counters and pos hold; err and period_done deassert.
//  - HOME = 8'h01 (DIR=0) / 8'h80 (DIR=1). succ(i): DIR=0 7->1 else i+1; DIR=1 0->6 else i-1 (home never a target).
//  - HUNT: valid word one-hot and not HOME -> nxt_tgt=succ(idx), pos=idx, good_cnt=1, go EXP_HOME; anything else stays in HUNT.
//  - EXP_HOME: valid word == HOME -> good_cnt++ (saturate 15), go EXP_TGT.
//  - EXP_TGT: valid word == 1<<nxt_tgt -> pos=nxt_tgt, nxt_tgt=succ(nxt_tgt), good_cnt++, go EXP_HOME;
//    period_done pulses when the accepted target is the final one of the sweep.
//  - Mismatch in EXP_HOME/EXP_TGT (incl. 8'h00, multi-hot, wrong index): go HUNT, good_cnt=0, locked=0;
//    err pulses only if locked was 1 on that cycle. The offending word is not re-evaluated as a HUNT candidate.
//  - locked sets on the edge where good_cnt reaches LOCK_WORDS; clears only on mismatch or reset.
//  - Reset mid-sweep: immediate return to reset values; resynchronises from the next valid target word.
//  - Generator output from its own reset (DIR=0): 01,02,01,04,...,01,80,01,02,... -> period of 14 valid words.
// CONFIGURATION
//  - SWEEP_CHK_ERRCNT_EN defined: err_count increments on every err pulse, saturates at 8'hFF, cleared only by reset.
//  - Not defined: err_count tied to 8'h00, no counter flops; all other behaviour identical.
// STRUCTURE
//  - Package sweep_chk_pkg: state typedef {HUNT, EXP_HOME, EXP_TGT}, HOME word/index constants per DIR, succ() function.
//  - Sub-module onehot8_enc (combinational): pat -> {is_onehot, idx[2:0]}; instanced once.
//  - Top holds FSM, nxt_tgt, good_cnt, output regs, optional err counter.
// TESTING
//  - Reset, then clean DIR=0 generator stream from 8'h01 -> first target 8'h02 enters EXP_HOME; locked=1 after 4th correct word; pos tracks 1..7; period_done every 14 valid words, on 8'h80.
//  - Locked, replace expected 8'h08 with 8'h10 -> err=1 for one cycle, locked=0, HUNT; next valid target relocks after LOCK_WORDS words; err_count=1 (macro on).
//  - Drop pat_valid low for 3 cycles mid-sweep -> outputs hold, no err; stream resumes and locked stays 1.
//  - DIR=1, stream 80,40,80,20,...,80,01 -> locked, pos 6..0, period_done on 8'h01.
//  - Feed 8'h00 and 8'h03 while unlocked -> no err, stays HUNT; while locked -> err pulse each time lock is lost.
//  - Assert rstn low mid-sweep for 1 cycle -> all outputs reset asynchronously; relock after LOCK_WORDS words.

Source files
------------

// File: rtl/sweep_chk_pkg.sv
// Shared types and direction-dependent constants for the sweep pattern checker.
// Home/target helpers take the sweep direction (0 = ascending, 1 = descending).
package sweep_chk_pkg;

   typedef enum logic [1:0] {
      StHunt    = 2'd0,
      StExpHome = 2'd1,
      StExpTgt  = 2'd2
   } state_e;

   localparam logic [7:0] HomeWordAsc  = 8'h01;
   localparam logic [7:0] HomeWordDesc = 8'h80;
   localparam logic [2:0] HomeIdxAsc   = 3'd0;
   localparam logic [2:0] HomeIdxDesc  = 3'd7;

   function automatic logic [7:0] home_word(input int unsigned dir);
      return (dir != 0) ? HomeWordDesc : HomeWordAsc;
   endfunction

   function automatic logic [2:0] home_idx(input int unsigned dir);
      return (dir != 0) ? HomeIdxDesc : HomeIdxAsc;
   endfunction

   // Final target of a sweep, after which the next target wraps past home.
   function automatic logic [2:0] last_idx(input int unsigned dir);
      return (dir != 0) ? 3'd0 : 3'd7;
   endfunction

   function automatic logic [2:0] succ(input logic [2:0] i, input int unsigned dir);
      if (dir == 0) begin
         return (i == 3'd7) ? 3'd1 : i + 3'd1;
      end
      return (i == 3'd0) ? 3'd6 : i - 3'd1;
   endfunction

endpackage

// File: rtl/onehot8_enc.sv
// Combinational one-hot detector and bit-index encoder for an 8-bit word.
// o_idx is only meaningful when o_is_onehot is high.
module onehot8_enc (
   input  logic [7:0] i_pat,
   output logic       o_is_onehot,
   output logic [2:0] o_idx
);

   always_comb begin
      o_idx = 3'd0;
      for (int b = 0; b < 8; b++) begin
         if (i_pat[b]) o_idx = 3'(b);
      end
      o_is_onehot = (i_pat != 8'd0) && ((i_pat & (i_pat - 8'd1)) == 8'd0);
   end

endmodule

// File: rtl/sweep_pattern_checker.sv
// Receive-side checker for the home-interleaved one-hot sweep pattern.
// Optional saturating error counter enabled by defining SWEEP_CHK_ERRCNT_EN.
module sweep_pattern_checker
   import sweep_chk_pkg::*;
#(
   parameter int unsigned DIR        = 0,
   parameter int unsigned LOCK_WORDS = 4
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic [7:0] i_pat,
   input  logic       i_pat_valid,
   output logic       o_locked,
   output logic [2:0] o_pos,
   output logic       o_err,
   output logic       o_period_done,
   output logic [7:0] o_err_count
);

   localparam logic [7:0] HomeWord  = home_word(DIR);
   localparam logic [2:0] HomeIdx   = home_idx(DIR);
   localparam logic [2:0] LastIdx   = last_idx(DIR);
   localparam logic [3:0] LockWords = 4'(LOCK_WORDS);

   state_e     r_state;
   logic [2:0] r_nxt_tgt;
   logic [3:0] r_good_cnt;
   logic       r_locked;
   logic [2:0] r_pos;
   logic       r_err;
   logic       r_period_done;

   logic       w_is_onehot;
   logic [2:0] w_idx;
   logic       w_home_hit;
   logic       w_tgt_hit;
   logic       w_candidate;
   logic       w_mismatch;
   logic       w_err_evt;
   logic [3:0] w_good_inc;

   onehot8_enc u_enc (
      .i_pat       (i_pat),
      .o_is_onehot (w_is_onehot),
      .o_idx       (w_idx)
   );

   always_comb begin
      w_home_hit  = (i_pat == HomeWord);
      w_tgt_hit   = (i_pat == (8'd1 << r_nxt_tgt));
      w_candidate = w_is_onehot && !w_home_hit;
      w_good_inc  = (r_good_cnt == 4'hF) ? 4'hF : r_good_cnt + 4'd1;
      w_mismatch  = i_pat_valid &&
                    (((r_state == StExpHome) && !w_home_hit) ||
                     ((r_state == StExpTgt) && !w_tgt_hit));
      w_err_evt   = w_mismatch && r_locked;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state       <= StHunt;
         r_nxt_tgt     <= HomeIdx;
         r_good_cnt    <= 4'd0;
         r_locked      <= 1'b0;
         r_pos         <= HomeIdx;
         r_err         <= 1'b0;
         r_period_done <= 1'b0;
      end else begin
         r_err         <= 1'b0;
         r_period_done <= 1'b0;
         if (i_pat_valid) begin
            if (w_mismatch) begin
               // Offending word is dropped, not reconsidered as a hunt candidate.
               r_state    <= StHunt;
               r_good_cnt <= 4'd0;
               r_locked   <= 1'b0;
               r_err      <= w_err_evt;
            end else begin
               unique case (r_state)
                  StHunt: begin
                     if (w_candidate) begin
                        r_state    <= StExpHome;
                        r_pos      <= w_idx;
                        r_nxt_tgt  <= succ(w_idx, DIR);
                        r_good_cnt <= 4'd1;
                        if (LockWords <= 4'd1) r_locked <= 1'b1;
                     end
                  end
                  StExpHome: begin
                     r_state    <= StExpTgt;
                     r_good_cnt <= w_good_inc;
                     if (w_good_inc >= LockWords) r_locked <= 1'b1;
                  end
                  StExpTgt: begin
                     r_state       <= StExpHome;
                     r_pos         <= r_nxt_tgt;
                     r_nxt_tgt     <= succ(r_nxt_tgt, DIR);
                     r_good_cnt    <= w_good_inc;
                     r_period_done <= (r_nxt_tgt == LastIdx);
                     if (w_good_inc >= LockWords) r_locked <= 1'b1;
                  end
                  default: r_state <= StHunt;
               endcase
            end
         end
      end
   end

`ifdef SWEEP_CHK_ERRCNT_EN
   logic [7:0] r_err_count;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_err_count <= 8'd0;
      end else if (w_err_evt && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign o_err_count = r_err_count;
`else
   assign o_err_count = 8'h00;
`endif

   assign o_locked      = r_locked;
   assign o_pos         = r_pos;
   assign o_err         = r_err;
   assign o_period_done = r_period_done;

endmodule

// File: tb/tb_sweep_pattern_checker.sv
// Scoreboard bench: both sweep directions driven by per-direction generator streams with
// random gaps, corruptions and resets; a sweep-list reference model predicts every output.
module tb_sweep_pattern_checker;

   localparam int unsigned LockWords = 4;

   logic       clk;
   logic       rstn;
   logic [7:0] pat0, pat1;
   logic       valid;
   logic       locked0, locked1, err0, err1, pd0, pd1;
   logic [2:0] pos0, pos1;
   logic [7:0] cnt0, cnt1;

   int n_cmp = 0;
   int n_bad = 0;

   logic [13:0] q0[$];
   logic [13:0] q1[$];

   // Reference model state, indexed by direction.
   bit m_hunt[2];
   bit m_want_home[2];
   bit m_lock[2];
   int m_nxt[2];
   int m_streak[2];
   int m_pos[2];
   int m_cnt[2];
   int g_pos[2];

   sweep_pattern_checker #(.DIR(0), .LOCK_WORDS(LockWords)) dut0 (
      .i_clk(clk), .i_rstn(rstn), .i_pat(pat0), .i_pat_valid(valid),
      .o_locked(locked0), .o_pos(pos0), .o_err(err0), .o_period_done(pd0),
      .o_err_count(cnt0)
   );

   sweep_pattern_checker #(.DIR(1), .LOCK_WORDS(LockWords)) dut1 (
      .i_clk(clk), .i_rstn(rstn), .i_pat(pat1), .i_pat_valid(valid),
      .o_locked(locked1), .o_pos(pos1), .o_err(err1), .o_period_done(pd1),
      .o_err_count(cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int home_of(int d);
      return (d == 0) ? 8'h01 : 8'h80;
   endfunction

   // k-th target (0..6) of a sweep.
   function automatic int tgt(int d, int k);
      return (d == 0) ? k + 1 : 6 - k;
   endfunction

   function automatic logic [13:0] pack(bit l, int p, bit e, bit pd, int c);
      logic [2:0] p3;
      logic [7:0] c8;
      p3 = 3'(p);
      c8 = 8'(c);
      return {l, p3, e, pd, c8};
   endfunction

   function automatic logic [13:0] reset_vec(int d);
      return pack(1'b0, (d == 0) ? 0 : 7, 1'b0, 1'b0, 0);
   endfunction

   function automatic void model_reset(int d);
      m_hunt[d]      = 1'b1;
      m_want_home[d] = 1'b0;
      m_lock[d]      = 1'b0;
      m_nxt[d]       = 0;
      m_streak[d]    = 0;
      m_pos[d]       = (d == 0) ? 0 : 7;
      m_cnt[d]       = 0;
   endfunction

   function automatic logic [13:0] model_step(int d, bit v, logic [7:0] w);
      bit e  = 1'b0;
      bit pd = 1'b0;
      bit ok = 1'b0;
      int cexp;
      if (v) begin
         if (m_hunt[d]) begin
            if ($countones(w) == 1 && int'(w) != home_of(d)) begin
               for (int k = 0; k < 7; k++) begin
                  if (int'(w) == (1 << tgt(d, k))) begin
                     m_pos[d] = tgt(d, k);
                     m_nxt[d] = (k + 1) % 7;
                  end
               end
               m_hunt[d]      = 1'b0;
               m_want_home[d] = 1'b1;
               m_streak[d]    = 1;
               ok = 1'b1;
            end
         end else if (m_want_home[d]) begin
            if (int'(w) == home_of(d)) begin
               m_want_home[d] = 1'b0;
               m_streak[d]    = (m_streak[d] < 15) ? m_streak[d] + 1 : 15;
               ok = 1'b1;
            end else begin
               e = 1'b1;
            end
         end else begin
            if (int'(w) == (1 << tgt(d, m_nxt[d]))) begin
               m_pos[d]       = tgt(d, m_nxt[d]);
               pd             = (m_nxt[d] == 6);
               m_nxt[d]       = (m_nxt[d] + 1) % 7;
               m_want_home[d] = 1'b1;
               m_streak[d]    = (m_streak[d] < 15) ? m_streak[d] + 1 : 15;
               ok = 1'b1;
            end else begin
               e = 1'b1;
            end
         end
         if (ok && m_streak[d] >= int'(LockWords)) m_lock[d] = 1'b1;
         if (e) begin
            e = m_lock[d];
            if (e && m_cnt[d] < 255) m_cnt[d]++;
            m_lock[d]   = 1'b0;
            m_hunt[d]   = 1'b1;
            m_streak[d] = 0;
         end
      end
`ifdef SWEEP_CHK_ERRCNT_EN
      cexp = m_cnt[d];
`else
      cexp = 0;
`endif
      return pack(m_lock[d], m_pos[d], e, pd, cexp);
   endfunction

   function automatic logic [7:0] gen_word(int d);
      if (g_pos[d] % 2 == 0) return 8'(home_of(d));
      return 8'(1 << tgt(d, g_pos[d] / 2));
   endfunction

   function automatic logic [7:0] corrupt(logic [7:0] w);
      logic [7:0] r;
      case ($urandom_range(0, 3))
         0: r = 8'h00;
         1: r = 8'h03;
         2: r = 8'($urandom);
         default: begin
            r = w;
            while (r == w) r = 8'(1 << $urandom_range(0, 7));
         end
      endcase
      return r;
   endfunction

   task automatic check(int d, logic [13:0] act, logic [13:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL dir%0d outputs t=%0t: got lock=%b pos=%0d err=%b pd=%b cnt=%0d, want lock=%b pos=%0d err=%b pd=%b cnt=%0d",
                  d, $time, act[13], act[12:10], act[9], act[8], act[7:0],
                  exp[13], exp[12:10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   // One clock of stimulus; corruption replaces the generator word but the stream moves on.
   task automatic drive(bit v, bit bad);
      logic [7:0] w[2];
      @(negedge clk);
      rstn  = 1'b1;
      valid = v;
      for (int d = 0; d < 2; d++) begin
         if (v) begin
            w[d] = gen_word(d);
            if (bad) w[d] = corrupt(w[d]);
            g_pos[d] = (g_pos[d] + 1) % 14;
         end else begin
            w[d] = 8'($urandom);
         end
      end
      pat0 = w[0];
      pat1 = w[1];
      q0.push_back(model_step(0, v, w[0]));
      q1.push_back(model_step(1, v, w[1]));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn  = 1'b0;
      valid = 1'b0;
      model_reset(0);
      model_reset(1);
      #1;
      check(0, {locked0, pos0, err0, pd0, cnt0}, reset_vec(0));
      check(1, {locked1, pos1, err1, pd1, cnt1}, reset_vec(1));
      q0.push_back(reset_vec(0));
      q1.push_back(reset_vec(1));
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() > 0) check(0, {locked0, pos0, err0, pd0, cnt0}, q0.pop_front());
         if (q1.size() > 0) check(1, {locked1, pos1, err1, pd1, cnt1}, q1.pop_front());
      end
   end

   initial begin : stimulus
      rstn  = 1'b0;
      valid = 1'b0;
      pat0  = 8'h00;
      pat1  = 8'h00;
      g_pos[0] = 0;
      g_pos[1] = 0;
      model_reset(0);
      model_reset(1);
      repeat (3) do_reset();
      repeat (40) drive(1'b1, 1'b0);
      drive(1'b1, 1'b1);
      repeat (30) drive(1'b1, 1'b0);
      repeat (3) drive(1'b0, 1'b0);
      repeat (20) drive(1'b1, 1'b0);
      do_reset();
      drive(1'b1, 1'b1);
      drive(1'b1, 1'b1);
      repeat (20) drive(1'b1, 1'b0);
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 299) == 0) do_reset();
         else drive($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 4);
      end
      drive(1'b0, 1'b0);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (q0.size() != 0 || q1.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
